keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with press/release debounce on a 1 ms tick.
// Optional auto-repeat while a key is held: define KEYPAD_SCAN_REPEAT_EN.
module keypad_scan #(
    parameter int unsigned DEB_CNT    = 4,
    parameter int unsigned REPEAT_DLY = 500,
    parameter int unsigned REPEAT_PER = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_1ms,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_vld,
    output logic       key_held
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned RPT_W = 10;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Reject configurations the 4-bit and 10-bit counters cannot represent.
    if (DEB_CNT < 2 || DEB_CNT > 15 ||
        REPEAT_DLY == 0 || REPEAT_DLY > 1023 ||
        REPEAT_PER == 0 || REPEAT_PER > 1023) begin : g_bad_cfg
        $error("keypad_scan: parameter out of range");
    end

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       row_meta;
    logic [3:0]       rs;
    logic [1:0]       col_idx;
    logic [1:0]       col_idx_nxt;
    logic [1:0]       row_idx;
    logic [1:0]       row_idx_nxt;
    logic [1:0]       low_idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       col_nxt;
    logic [3:0]       key_nxt;
    logic             key_vld_nxt;
    logic             key_held_nxt;
    logic             any_low;
    logic             row_hit;
    logic             rpt_fire;

    // Two-flop synchronizer; rows idle high so reset to all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            rs       <= 4'b1111;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    // Lowest-index low row wins when several rows are pressed in one column.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) begin
                low_idx = 2'(i);
            end
        end
    end

    assign any_low = ~(&rs);
    assign row_hit = ~rs[row_idx];
    assign cnt_inc = cnt + CNT_W'(1);

`ifdef KEYPAD_SCAN_REPEAT_EN
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic [RPT_W-1:0] rpt_inc;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_first;
    logic             rpt_first_nxt;

    assign rpt_inc    = rpt_cnt + RPT_W'(1);
    assign rpt_target = rpt_first ? RPT_W'(REPEAT_DLY) : RPT_W'(REPEAT_PER);

    // Counts held milliseconds; frozen while a release is being confirmed.
    always_comb begin
        rpt_cnt_nxt   = rpt_cnt;
        rpt_first_nxt = rpt_first;
        rpt_fire      = 1'b0;
        if (ce_1ms) begin
            if (state == DEBOUNCE) begin
                rpt_cnt_nxt   = '0;
                rpt_first_nxt = 1'b1;
            end else if (state == HELD && row_hit) begin
                if (rpt_inc == rpt_target) begin
                    rpt_fire      = 1'b1;
                    rpt_cnt_nxt   = '0;
                    rpt_first_nxt = 1'b0;
                end else begin
                    rpt_cnt_nxt = rpt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt_nxt;
            rpt_first <= rpt_first_nxt;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Next-state and output decode; everything except the key_vld clear waits for ce_1ms.
    always_comb begin
        state_nxt    = state;
        col_idx_nxt  = col_idx;
        row_idx_nxt  = row_idx;
        cnt_nxt      = cnt;
        key_nxt      = key;
        key_vld_nxt  = 1'b0;
        key_held_nxt = key_held;
        if (ce_1ms) begin
            unique case (state)
                SCAN: begin
                    if (any_low) begin
                        row_idx_nxt = low_idx;
                        cnt_nxt     = CNT_W'(1);
                        state_nxt   = DEBOUNCE;
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_hit) begin
                        if (cnt_inc == CNT_W'(DEB_CNT)) begin
                            key_nxt      = {col_idx, row_idx};
                            key_vld_nxt  = 1'b1;
                            key_held_nxt = 1'b1;
                            cnt_nxt      = '0;
                            state_nxt    = HELD;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt     = '0;
                        col_idx_nxt = col_idx + 2'd1;
                        state_nxt   = SCAN;
                    end
                end
                HELD: begin
                    if (!row_hit) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = RELEASE;
                    end else begin
                        key_vld_nxt = rpt_fire;
                    end
                end
                RELEASE: begin
                    if (!row_hit) begin
                        if (cnt_inc == CNT_W'(DEB_CNT)) begin
                            key_held_nxt = 1'b0;
                            cnt_nxt      = '0;
                            col_idx_nxt  = col_idx + 2'd1;
                            state_nxt    = SCAN;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = HELD;
                    end
                end
            endcase
        end
    end

    assign col_nxt = ~(4'b0001 << col_idx_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SCAN;
            col_idx  <= 2'd0;
            row_idx  <= 2'd0;
            cnt      <= '0;
            col      <= 4'b1110;
            key      <= 4'h0;
            key_vld  <= 1'b0;
            key_held <= 1'b0;
        end else begin
            state    <= state_nxt;
            col_idx  <= col_idx_nxt;
            row_idx  <= row_idx_nxt;
            cnt      <= cnt_nxt;
            col      <= col_nxt;
            key      <= key_nxt;
            key_vld  <= key_vld_nxt;
            key_held <= key_held_nxt;
        end
    end

endmodule
